// File: rtl/rm3100_pkg.sv
// Shared constants and state encodings for the RM3100 measurement sequencer.
package rm3100_pkg;

  localparam logic [6:0] ADDR_POLL   = 7'h00;
  localparam logic [6:0] ADDR_CCRX   = 7'h04;
  localparam logic [6:0] ADDR_STATUS = 7'h34;
  localparam logic [6:0] ADDR_MX     = 7'h24;

  localparam int DRDY_BIT = 7;

  typedef enum logic [2:0] {
    WAIT_START,
    CFG,
    IDLE,
    POLL_WR,
    STAT_RD,
    DATA_RD,
    OUT
  } seq_state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_WAIT,
    X_GAP
  } xfer_state_t;

endpackage

// File: rtl/rm3100_xfer.sv
// One SPI engine transaction: issue a request, wait for the done edge, then
// hold off for a fixed gap before reporting completion to the sequencer.
module rm3100_xfer
  import rm3100_pkg::*;
#(
  parameter int GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  addr,
  input  logic [7:0]  wdata,
  input  logic        wr,
  output logic [7:0]  rdata,
  output logic        xfer_done,
  output logic        spi_req,
  output logic        spi_wr_en,
  output logic [15:0] spi_data_tx,
  input  logic [7:0]  spi_data_rx,
  input  logic        spi_done
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

  xfer_state_t state_reg;
  logic        spi_done_d;
  logic [15:0] gap_cnt_reg;
  logic        done_rise;

  // Engine may hold done as a level; only a fresh rising edge completes a transfer.
  assign done_rise = spi_done & ~spi_done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= X_IDLE;
      spi_done_d  <= 1'b0;
      gap_cnt_reg <= 16'd0;
      rdata       <= 8'd0;
      xfer_done   <= 1'b0;
      spi_req     <= 1'b0;
      spi_wr_en   <= 1'b0;
      spi_data_tx <= 16'd0;
    end else begin
      spi_done_d <= spi_done;
      spi_req    <= 1'b0;
      xfer_done  <= 1'b0;
      case (state_reg)
        X_IDLE: begin
          if (start) begin
            spi_data_tx <= {wdata, 1'b0, addr};
            spi_wr_en   <= wr;
            spi_req     <= 1'b1;
            state_reg   <= X_WAIT;
          end
        end
        X_WAIT: begin
          if (done_rise) begin
            rdata       <= spi_data_rx;
            gap_cnt_reg <= 16'd0;
            state_reg   <= X_GAP;
          end
        end
        X_GAP: begin
          if (gap_cnt_reg >= GAP_LAST) begin
            xfer_done <= 1'b1;
            state_reg <= X_IDLE;
          end else if (gap_cnt_reg != 16'hFFFF) begin
            gap_cnt_reg <= gap_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rm3100_seq.sv
// RM3100 sequencer: programs the cycle-count registers once, then on request
// polls for data-ready and burst-reads the three 24-bit axis results.
module rm3100_seq
  import rm3100_pkg::*;
#(
  parameter logic [15:0] CCR_VAL     = 16'h00C8,
  parameter logic [7:0]  POLL_MASK   = 8'h70,
  parameter int          GAP_CYC     = 16,
  parameter int          STARTUP_CYC = 512,
  parameter int          POLL_LIMIT  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        measure_req,
  output logic        spi_req,
  output logic        spi_wr_en,
  output logic [15:0] spi_data_tx,
  input  logic [7:0]  spi_data_rx,
  input  logic        spi_done,
  output logic        busy,
  output logic        cfg_done,
  output logic [23:0] mag_x,
  output logic [23:0] mag_y,
  output logic [23:0] mag_z,
  output logic        mag_valid,
  output logic        timeout_err
);

  localparam logic [15:0] START_LAST = (STARTUP_CYC > 0) ? 16'(STARTUP_CYC - 1) : 16'd0;
  localparam logic [15:0] POLL_MAX   = (POLL_LIMIT > 0) ? 16'(POLL_LIMIT) : 16'd1;

  seq_state_t  state_reg;
  logic [15:0] startup_cnt_reg;
  logic [2:0]  cfg_idx_reg;
  logic [3:0]  byte_idx_reg;
  logic [15:0] poll_cnt_reg;
  logic [71:0] data_buf_reg;
  logic        launched_reg;
  logic        start_reg;
  logic [6:0]  addr_reg;
  logic [7:0]  wdata_reg;
  logic        wr_reg;

  logic [7:0]  xfer_rdata;
  logic        xfer_done;
  logic [6:0]  op_addr;
  logic [7:0]  op_wdata;
  logic        op_wr;
  logic        op_active;
  logic [15:0] poll_next;

  always_comb begin
    op_addr   = ADDR_POLL;
    op_wdata  = 8'h00;
    op_wr     = 1'b0;
    op_active = 1'b1;
    case (state_reg)
      CFG: begin
        // Even index carries the CCR high byte, odd index the low byte.
        op_addr  = ADDR_CCRX + {4'd0, cfg_idx_reg};
        op_wdata = cfg_idx_reg[0] ? CCR_VAL[7:0] : CCR_VAL[15:8];
        op_wr    = 1'b1;
      end
      POLL_WR: begin
        op_wdata = POLL_MASK;
        op_wr    = 1'b1;
      end
      STAT_RD: op_addr = ADDR_STATUS;
      DATA_RD: op_addr = ADDR_MX + {3'd0, byte_idx_reg};
      default: op_active = 1'b0;
    endcase
  end

  assign poll_next = (poll_cnt_reg == 16'hFFFF) ? poll_cnt_reg : poll_cnt_reg + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= WAIT_START;
      startup_cnt_reg <= 16'd0;
      cfg_idx_reg     <= 3'd0;
      byte_idx_reg    <= 4'd0;
      poll_cnt_reg    <= 16'd0;
      data_buf_reg    <= 72'd0;
      launched_reg    <= 1'b0;
      start_reg       <= 1'b0;
      addr_reg        <= 7'd0;
      wdata_reg       <= 8'd0;
      wr_reg          <= 1'b0;
      busy            <= 1'b0;
      cfg_done        <= 1'b0;
      mag_x           <= 24'd0;
      mag_y           <= 24'd0;
      mag_z           <= 24'd0;
      mag_valid       <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      start_reg   <= 1'b0;
      mag_valid   <= 1'b0;
      timeout_err <= 1'b0;

      // Each operating state launches exactly one transfer and waits for its completion.
      if (op_active && !launched_reg) begin
        start_reg    <= 1'b1;
        addr_reg     <= op_addr;
        wdata_reg    <= op_wdata;
        wr_reg       <= op_wr;
        launched_reg <= 1'b1;
      end

      case (state_reg)
        WAIT_START: begin
          busy <= 1'b1;
          if (startup_cnt_reg >= START_LAST) begin
            cfg_idx_reg <= 3'd0;
            state_reg   <= CFG;
          end else begin
            startup_cnt_reg <= startup_cnt_reg + 16'd1;
          end
        end
        CFG: begin
          if (xfer_done) begin
            launched_reg <= 1'b0;
            if (cfg_idx_reg == 3'd5) begin
              cfg_done  <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              cfg_idx_reg <= cfg_idx_reg + 3'd1;
            end
          end
        end
        IDLE: begin
          if (measure_req) begin
            busy      <= 1'b1;
            state_reg <= POLL_WR;
          end
        end
        POLL_WR: begin
          if (xfer_done) begin
            launched_reg <= 1'b0;
            poll_cnt_reg <= 16'd0;
            state_reg    <= STAT_RD;
          end
        end
        STAT_RD: begin
          if (xfer_done) begin
            launched_reg <= 1'b0;
            poll_cnt_reg <= poll_next;
            if (xfer_rdata[DRDY_BIT]) begin
              byte_idx_reg <= 4'd0;
              state_reg    <= DATA_RD;
            end else if (poll_next >= POLL_MAX) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state_reg   <= IDLE;
            end
          end
        end
        DATA_RD: begin
          if (xfer_done) begin
            launched_reg <= 1'b0;
            data_buf_reg <= {data_buf_reg[63:0], xfer_rdata};
            if (byte_idx_reg == 4'd8) begin
              state_reg <= OUT;
            end else begin
              byte_idx_reg <= byte_idx_reg + 4'd1;
            end
          end
        end
        OUT: begin
          mag_x     <= data_buf_reg[71:48];
          mag_y     <= data_buf_reg[47:24];
          mag_z     <= data_buf_reg[23:0];
          mag_valid <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= WAIT_START;
      endcase
    end
  end

  rm3100_xfer #(
    .GAP_CYC(GAP_CYC)
  ) u_xfer (
    .clk        (clk),
    .rst        (rst),
    .start      (start_reg),
    .addr       (addr_reg),
    .wdata      (wdata_reg),
    .wr         (wr_reg),
    .rdata      (xfer_rdata),
    .xfer_done  (xfer_done),
    .spi_req    (spi_req),
    .spi_wr_en  (spi_wr_en),
    .spi_data_tx(spi_data_tx),
    .spi_data_rx(spi_data_rx),
    .spi_done   (spi_done)
  );

endmodule

// File: tb/tb_rm3100_seq.sv
// Bench for rm3100_seq: scripted SPI engine model, request/result scoreboards.
module tb_rm3100_seq;

  localparam int STARTUP = 512;
  localparam int PLIM    = 4;

  logic        clk;
  logic        rst;
  logic        measure_req;
  logic        spi_req;
  logic        spi_wr_en;
  logic [15:0] spi_data_tx;
  logic [7:0]  spi_data_rx;
  logic        spi_done;
  logic        busy;
  logic        cfg_done;
  logic [23:0] mag_x;
  logic [23:0] mag_y;
  logic [23:0] mag_z;
  logic        mag_valid;
  logic        timeout_err;

  rm3100_seq #(
    .POLL_LIMIT(PLIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .measure_req(measure_req),
    .spi_req    (spi_req),
    .spi_wr_en  (spi_wr_en),
    .spi_data_tx(spi_data_tx),
    .spi_data_rx(spi_data_rx),
    .spi_done   (spi_done),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .mag_x      (mag_x),
    .mag_y      (mag_y),
    .mag_z      (mag_z),
    .mag_valid  (mag_valid),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] tx;
  } xact_t;

  typedef struct {
    int          n_zero;
    logic        drdy;
    logic [71:0] data;
    logic        level;
  } meas_t;

  xact_t       cfg_tab[6];
  meas_t       meas_tab[3];
  xact_t       exp_q[$];
  logic [71:0] exp_mag_q[$];
  logic [7:0]  status_q[$];
  logic [7:0]  data_bytes[9];

  int   checks = 0;
  int   failures = 0;
  int   req_cnt = 0;
  int   data_req_cnt = 0;
  int   mag_cnt = 0;
  int   to_cnt = 0;
  logic level_mode = 1'b0;
  logic mv_prev = 1'b0;
  logic to_prev = 1'b0;

  task automatic check(input string name, input bit ok, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Engine model: done 40 cycles after each request, response chosen by address.
  initial begin : engine
    int          cnt;
    logic [7:0]  resp;
    logic [6:0]  a;
    xact_t       cur;
    xact_t       e;
    bit          moved;
    cnt   = 0;
    resp  = 8'h00;
    cur   = '0;
    moved = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cnt      = 0;
        spi_done = 1'b0;
      end else if (spi_req) begin
        cur = '{spi_wr_en, spi_data_tx};
        req_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", 1'b0, {55'd0, cur}, 72'd0);
        end else begin
          e = exp_q.pop_front();
          check("req", cur == e, {55'd0, cur}, {55'd0, e});
        end
        a = spi_data_tx[6:0];
        resp = 8'h00;
        if (a == 7'h34) begin
          if (status_q.size() > 0) resp = status_q.pop_front();
        end else if (a >= 7'h24 && a <= 7'h2C) begin
          resp = data_bytes[a - 7'h24];
          data_req_cnt++;
        end
        cnt      = 40;
        spi_done = 1'b0;
        moved    = 1'b0;
      end else if (cnt > 0) begin
        if ({spi_wr_en, spi_data_tx} != cur) moved = 1'b1;
        cnt--;
        if (cnt == 0) begin
          check("tx_held", !moved, {71'd0, moved}, 72'd0);
          spi_done    = 1'b1;
          spi_data_rx = resp;
        end
      end else if (!level_mode) begin
        spi_done = 1'b0;
      end
    end
  end

  // Result monitor: every mag_valid is matched against the expected-result queue.
  initial begin : result_mon
    logic [71:0] em;
    forever begin
      @(negedge clk);
      if (mag_valid) begin
        mag_cnt++;
        if (exp_mag_q.size() == 0) begin
          check("unexpected_mag", 1'b0, {mag_x, mag_y, mag_z}, 72'd0);
        end else begin
          em = exp_mag_q.pop_front();
          check("mag", {mag_x, mag_y, mag_z} === em, {mag_x, mag_y, mag_z}, em);
        end
        if (mv_prev) check("mag_valid_width", 1'b0, 72'd2, 72'd1);
      end
      if (timeout_err) begin
        to_cnt++;
        if (to_prev) check("timeout_width", 1'b0, 72'd2, 72'd1);
      end
      mv_prev = mag_valid;
      to_prev = timeout_err;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_cfg();
    for (int i = 0; i < 6; i++) exp_q.push_back(cfg_tab[i]);
  endtask

  task automatic push_meas(input int n_stat, input int n_data);
    exp_q.push_back('{1'b1, 16'h7000});
    for (int i = 0; i < n_stat; i++) exp_q.push_back('{1'b0, 16'h0034});
    for (int i = 0; i < n_data; i++) exp_q.push_back('{1'b0, 16'h0024 + 16'(i)});
  endtask

  task automatic load_bytes(input logic [71:0] v);
    for (int i = 0; i < 9; i++) data_bytes[i] = v[71-8*i -: 8];
  endtask

  task automatic pulse_req(input int len);
    measure_req = 1'b1;
    repeat (len) @(negedge clk);
    measure_req = 1'b0;
  endtask

  task automatic wait_first_req(input string name);
    int n;
    n = 0;
    while (!spi_req && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, spi_req === 1'b1 && n >= STARTUP, 72'(n), 72'(STARTUP));
  endtask

  task automatic wait_cfg(input string name);
    for (int i = 0; i < 4000 && cfg_done !== 1'b1; i++) @(negedge clk);
    check(name, cfg_done === 1'b1, {71'd0, cfg_done}, 72'd1);
  endtask

  task automatic wait_result(input int m0, input int o0);
    for (int i = 0; i < 5000 && mag_cnt == m0 && to_cnt == o0; i++) @(negedge clk);
  endtask

  initial begin : main
    int          r0;
    int          m0;
    int          o0;
    int          d0;
    int          nreq;
    logic [71:0] last_mag;

    cfg_tab[0] = '{1'b1, 16'h0004};
    cfg_tab[1] = '{1'b1, 16'hC805};
    cfg_tab[2] = '{1'b1, 16'h0006};
    cfg_tab[3] = '{1'b1, 16'hC807};
    cfg_tab[4] = '{1'b1, 16'h0008};
    cfg_tab[5] = '{1'b1, 16'hC809};
    meas_tab[0] = '{2, 1'b1, 72'h010203FFFFFE800000, 1'b0};
    meas_tab[1] = '{0, 1'b0, 72'h000000000000000000, 1'b0};
    meas_tab[2] = '{1, 1'b1, 72'h7FFFFF000001123456, 1'b1};
    last_mag = 72'd0;

    measure_req = 1'b0;
    spi_done    = 1'b0;
    spi_data_rx = 8'h00;
    rst = 1'b1;
    #1 rst = 1'b0;
    cycles(3);
    check("rst_ctrl", {busy, cfg_done, mag_valid, timeout_err, spi_req, spi_wr_en} === 6'd0,
          {66'd0, busy, cfg_done, mag_valid, timeout_err, spi_req, spi_wr_en}, 72'd0);
    check("rst_tx", spi_data_tx === 16'd0, {56'd0, spi_data_tx}, 72'd0);
    check("rst_mag", {mag_x, mag_y, mag_z} === 72'd0, {mag_x, mag_y, mag_z}, 72'd0);

    // Configuration after reset release
    push_cfg();
    rst = 1'b1;
    wait_first_req("startup_delay");
    wait_cfg("cfg_done");
    cycles(20);
    check("cfg_req_count", req_cnt == 6, 72'(req_cnt), 72'd6);
    check("cfg_busy", busy === 1'b0, {71'd0, busy}, 72'd0);
    check("cfg_queue_empty", exp_q.size() == 0, 72'(exp_q.size()), 72'd0);

    // Table-driven measurements: normal, timeout, level-held done
    for (int t = 0; t < 3; t++) begin
      r0 = req_cnt;
      m0 = mag_cnt;
      o0 = to_cnt;
      level_mode = meas_tab[t].level;
      load_bytes(meas_tab[t].data);
      status_q.delete();
      for (int i = 0; i < meas_tab[t].n_zero; i++) status_q.push_back(8'h00);
      if (meas_tab[t].drdy) begin
        status_q.push_back(8'h80);
        push_meas(meas_tab[t].n_zero + 1, 9);
        exp_mag_q.push_back(meas_tab[t].data);
        nreq = meas_tab[t].n_zero + 11;
      end else begin
        push_meas(PLIM, 0);
        nreq = 1 + PLIM;
      end
      pulse_req(1);
      wait_result(m0, o0);
      cycles(5);
      check("meas_mag_count", mag_cnt == m0 + (meas_tab[t].drdy ? 1 : 0), 72'(mag_cnt - m0),
            72'(meas_tab[t].drdy ? 1 : 0));
      check("meas_timeout_count", to_cnt == o0 + (meas_tab[t].drdy ? 0 : 1), 72'(to_cnt - o0),
            72'(meas_tab[t].drdy ? 0 : 1));
      check("meas_req_count", req_cnt - r0 == nreq, 72'(req_cnt - r0), 72'(nreq));
      check("meas_busy", busy === 1'b0, {71'd0, busy}, 72'd0);
      check("meas_queue_empty", exp_q.size() == 0, 72'(exp_q.size()), 72'd0);
      if (meas_tab[t].drdy) last_mag = meas_tab[t].data;
      else check("timeout_mag_kept", {mag_x, mag_y, mag_z} === last_mag, {mag_x, mag_y, mag_z}, last_mag);
    end

    // Held request plus requests while busy: exactly one measurement
    level_mode = 1'b0;
    r0 = req_cnt;
    m0 = mag_cnt;
    load_bytes(72'hA55A3CC30FF0112233);
    status_q.delete();
    status_q.push_back(8'h80);
    push_meas(1, 9);
    exp_mag_q.push_back(72'hA55A3CC30FF0112233);
    pulse_req(3);
    cycles(100);
    check("busy_during_meas", busy === 1'b1, {71'd0, busy}, 72'd1);
    pulse_req(1);
    cycles(300);
    pulse_req(2);
    wait_result(m0, to_cnt);
    cycles(200);
    check("drop_mag_count", mag_cnt == m0 + 1, 72'(mag_cnt - m0), 72'd1);
    check("drop_req_count", req_cnt - r0 == 11, 72'(req_cnt - r0), 72'd11);
    check("drop_busy", busy === 1'b0, {71'd0, busy}, 72'd0);
    check("drop_queue_empty", exp_q.size() == 0, 72'(exp_q.size()), 72'd0);

    // Reset in the middle of the data burst
    d0 = data_req_cnt;
    load_bytes(72'h111111222222333333);
    status_q.delete();
    status_q.push_back(8'h80);
    push_meas(1, 9);
    pulse_req(1);
    for (int i = 0; i < 3000 && data_req_cnt < d0 + 5; i++) @(negedge clk);
    check("reached_byte5", data_req_cnt == d0 + 5, 72'(data_req_cnt - d0), 72'd5);
    cycles(10);
    m0 = mag_cnt;
    #2 rst = 1'b0;
    #1;
    check("async_rst_ctrl", {busy, cfg_done, spi_req, spi_wr_en} === 4'd0,
          {68'd0, busy, cfg_done, spi_req, spi_wr_en}, 72'd0);
    check("async_rst_tx", spi_data_tx === 16'd0, {56'd0, spi_data_tx}, 72'd0);
    check("async_rst_mag", {mag_x, mag_y, mag_z} === 72'd0, {mag_x, mag_y, mag_z}, 72'd0);
    exp_q.delete();
    status_q.delete();
    cycles(3);
    push_cfg();
    rst = 1'b1;
    wait_first_req("restart_delay");
    wait_cfg("cfg_rerun");
    cycles(20);
    check("rst_no_mag", mag_cnt == m0, 72'(mag_cnt - m0), 72'd0);
    check("rerun_queue_empty", exp_q.size() == 0, 72'(exp_q.size()), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
